// File: rtl/mem_clint_req.sv
// MEM-stage initiator for the CLINT bus: issues one load/store, waits for ready,
// and returns lane-extracted, extended load data with a one-cycle done pulse.
module mem_clint_req #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              mem_done_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_err_o,
  output logic              mem_stall_o,
  output logic              clint_valid_o,
  output logic [ADDR_W-1:0] clint_addr_o,
  output logic [DATA_W-1:0] clint_data_write_o,
  output logic [1:0]        clint_size_o,
  output logic [1:0]        clint_req_o,
  input  logic              clint_ready_i,
  input  logic [DATA_W-1:0] clint_data_read_i,
  input  logic [1:0]        clint_resp_i
);

  localparam int unsigned CNT_W     = 8;
  localparam logic [1:0]  REQ_READ  = 2'd0;
  localparam logic [1:0]  REQ_WRITE = 2'd1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         addr_lo_q;
  logic [1:0]         size_q;
  logic               write_q;
  logic               unsigned_q;

  logic               aligned_c;
  logic [5:0]         lane_sh_in_c;
  logic [5:0]         lane_sh_q_c;
  logic [DATA_W-1:0]  raw_c;
  logic [DATA_W-1:0]  load_c;

  assign lane_sh_in_c = {mem_addr_i[2:0], 3'b000};
  assign lane_sh_q_c  = {addr_lo_q, 3'b000};
  assign raw_c        = clint_data_read_i >> lane_sh_q_c;

  // Natural alignment: address must be a multiple of the access size.
  always_comb begin
    aligned_c = 1'b1;
    case (mem_size_i)
      2'd0:    aligned_c = 1'b1;
      2'd1:    aligned_c = ~mem_addr_i[0];
      2'd2:    aligned_c = (mem_addr_i[1:0] == 2'b00);
      default: aligned_c = (mem_addr_i[2:0] == 3'b000);
    endcase
  end

  // Truncate the lane-shifted read data to the access size, then extend.
  always_comb begin
    load_c = raw_c;
    case (size_q)
      2'd0:    load_c = {{(DATA_W-8){~unsigned_q & raw_c[7]}}, raw_c[7:0]};
      2'd1:    load_c = {{(DATA_W-16){~unsigned_q & raw_c[15]}}, raw_c[15:0]};
      2'd2:    load_c = {{(DATA_W-32){~unsigned_q & raw_c[31]}}, raw_c[31:0]};
      default: load_c = raw_c;
    endcase
  end

  // Stall decodes the live request in IDLE, so it is not a registered output.
  assign mem_stall_o = rst & ((state == REQ) | ((state == IDLE) & mem_valid_i));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      cnt                <= '0;
      addr_lo_q          <= '0;
      size_q             <= '0;
      write_q            <= 1'b0;
      unsigned_q         <= 1'b0;
      mem_done_o         <= 1'b0;
      mem_rdata_o        <= '0;
      mem_err_o          <= 1'b0;
      clint_valid_o      <= 1'b0;
      clint_addr_o       <= '0;
      clint_data_write_o <= '0;
      clint_size_o       <= '0;
      clint_req_o        <= '0;
    end else begin
      mem_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_valid_i) begin
            addr_lo_q  <= mem_addr_i[2:0];
            size_q     <= mem_size_i;
            write_q    <= mem_write_i;
            unsigned_q <= mem_unsigned_i;
            cnt        <= '0;
            if (aligned_c) begin
              state              <= REQ;
              clint_valid_o      <= 1'b1;
              clint_addr_o       <= mem_addr_i;
              clint_size_o       <= mem_size_i;
              clint_req_o        <= mem_write_i ? REQ_WRITE : REQ_READ;
              clint_data_write_o <= mem_write_i ? (mem_wdata_i << lane_sh_in_c) : '0;
            end else begin
              state       <= DONE;
              mem_done_o  <= 1'b1;
              mem_err_o   <= 1'b1;
              mem_rdata_o <= '0;
            end
          end
        end
        REQ: begin
          if (clint_ready_i || (cnt == CNT_W'(TIMEOUT - 1))) begin
            state              <= DONE;
            mem_done_o         <= 1'b1;
            clint_valid_o      <= 1'b0;
            clint_addr_o       <= '0;
            clint_data_write_o <= '0;
            clint_size_o       <= '0;
            clint_req_o        <= '0;
            if (clint_ready_i) begin
              mem_err_o   <= (clint_resp_i != 2'b00);
              mem_rdata_o <= write_q ? '0 : load_c;
            end else begin
              mem_err_o   <= 1'b1;
              mem_rdata_o <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state       <= IDLE;
          cnt         <= '0;
          mem_err_o   <= 1'b0;
          mem_rdata_o <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_clint_req.sv
// Scoreboard bench for mem_clint_req: a simple CLINT responder model, per-access
// bus/latency checks, and a done-pulse monitor that pops expected results.
module tb_mem_clint_req;

  localparam int unsigned TIMEOUT       = 255;
  localparam logic [63:0] MTIME_ADDR    = 64'h0000_0000_0200_BFF8;
  localparam logic [63:0] MTIMECMP_ADDR = 64'h0000_0000_0200_4000;
  localparam logic [1:0]  REQ_READ      = 2'd0;
  localparam logic [1:0]  REQ_WRITE     = 2'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i, mem_write_i, mem_unsigned_i;
  logic [63:0] mem_addr_i, mem_wdata_i;
  logic [1:0]  mem_size_i;
  logic        mem_done_o, mem_err_o, mem_stall_o;
  logic [63:0] mem_rdata_o;
  logic        clint_valid_o;
  logic [63:0] clint_addr_o, clint_data_write_o;
  logic [1:0]  clint_size_o, clint_req_o;
  logic        clint_ready_i;
  logic [63:0] clint_data_read_i;
  logic [1:0]  clint_resp_i;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int          rsp_delay = 0;
  logic [63:0] rsp_data  = '0;
  logic [1:0]  rsp_resp  = '0;
  int          wait_cnt  = 0;

  mem_clint_req #(.DATA_W(64), .ADDR_W(64), .TIMEOUT(TIMEOUT)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_valid_i        (mem_valid_i),
    .mem_write_i        (mem_write_i),
    .mem_addr_i         (mem_addr_i),
    .mem_size_i         (mem_size_i),
    .mem_unsigned_i     (mem_unsigned_i),
    .mem_wdata_i        (mem_wdata_i),
    .mem_done_o         (mem_done_o),
    .mem_rdata_o        (mem_rdata_o),
    .mem_err_o          (mem_err_o),
    .mem_stall_o        (mem_stall_o),
    .clint_valid_o      (clint_valid_o),
    .clint_addr_o       (clint_addr_o),
    .clint_data_write_o (clint_data_write_o),
    .clint_size_o       (clint_size_o),
    .clint_req_o        (clint_req_o),
    .clint_ready_i      (clint_ready_i),
    .clint_data_read_i  (clint_data_read_i),
    .clint_resp_i       (clint_resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Responder: assert ready after rsp_delay cycles of valid.
  always @(negedge clk) begin
    if (clint_valid_o) begin
      if (wait_cnt == rsp_delay) begin
        clint_ready_i     = 1'b1;
        clint_data_read_i = rsp_data;
        clint_resp_i      = rsp_resp;
      end else begin
        clint_ready_i     = 1'b0;
        clint_data_read_i = '0;
        clint_resp_i      = '0;
      end
      wait_cnt++;
    end else begin
      clint_ready_i     = 1'b0;
      clint_data_read_i = '0;
      clint_resp_i      = '0;
      wait_cnt          = 0;
    end
  end

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mem_done_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(mem_done_o), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_rdata", mem_rdata_o, e.rdata);
        chk("sb_err", 64'(mem_err_o), 64'(e.err));
      end
    end
  end

  task automatic run_access(input string tag, input logic wr, input logic [63:0] addr,
                            input logic [1:0] size, input logic uns, input logic [63:0] wdata,
                            input int delay, input logic [63:0] rdat, input logic [1:0] resp,
                            input logic [63:0] exp_rd, input logic exp_err,
                            input int exp_vcnt, input int exp_lat, input logic [63:0] exp_wbus);
    exp_t e;
    int   vcnt = 0;
    int   lat  = 0;
    bit   seen = 0;
    bit   bus_bad = 0;
    bit   stall_bad = 0;
    @(negedge clk);
    rsp_delay = delay; rsp_data = rdat; rsp_resp = resp;
    mem_valid_i = 1'b1; mem_write_i = wr; mem_addr_i = addr; mem_size_i = size;
    mem_unsigned_i = uns; mem_wdata_i = wdata;
    e.rdata = exp_rd; e.err = exp_err;
    sb.push_back(e);
    #1 chk({tag, "_stall_accept"}, 64'(mem_stall_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
    mem_valid_i = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      if (mem_done_o) begin
        seen = 1;
        lat  = i;
        break;
      end
      if (clint_valid_o) begin
        vcnt++;
        if (clint_addr_o !== addr || clint_size_o !== size ||
            clint_req_o !== (wr ? REQ_WRITE : REQ_READ) || clint_data_write_o !== exp_wbus)
          bus_bad = 1;
      end
      if (!mem_stall_o) stall_bad = 1;
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_valid_cycles"}, 64'(vcnt), 64'(exp_vcnt));
    chk({tag, "_bus_stable"}, 64'(bus_bad), 64'd0);
    chk({tag, "_stall_busy"}, 64'(stall_bad), 64'd0);
    chk({tag, "_stall_done"}, 64'(mem_stall_o), 64'd0);
    @(negedge clk);
    chk({tag, "_done_once"}, 64'(mem_done_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    mem_valid_i = 1'b0; mem_write_i = 1'b0; mem_addr_i = '0; mem_size_i = '0;
    mem_unsigned_i = 1'b0; mem_wdata_i = '0;
    clint_ready_i = 1'b0; clint_data_read_i = '0; clint_resp_i = '0;
    #1;
    chk("rst_valid", 64'(clint_valid_o), 64'd0);
    chk("rst_done", 64'(mem_done_o), 64'd0);
    chk("rst_stall", 64'(mem_stall_o), 64'd0);
    chk("rst_rdata", mem_rdata_o, 64'd0);
    chk("rst_wbus", clint_data_write_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_access("ld_dword", 1'b0, MTIME_ADDR, 2'd3, 1'b0, '0, 0, 64'h0000_0001_2345_6789, 2'b00,
               64'h0000_0001_2345_6789, 1'b0, 1, 2, 64'd0);
    run_access("ld_byte_s", 1'b0, MTIMECMP_ADDR + 64'd3, 2'd0, 1'b0, '0, 0, 64'h0000_0000_8000_0000,
               2'b00, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1, 2, 64'd0);
    run_access("ld_byte_u", 1'b0, MTIMECMP_ADDR + 64'd3, 2'd0, 1'b1, '0, 0, 64'h0000_0000_8000_0000,
               2'b00, 64'h0000_0000_0000_0080, 1'b0, 1, 2, 64'd0);
    run_access("st_word", 1'b1, MTIMECMP_ADDR + 64'd4, 2'd2, 1'b0, 64'h0000_0000_DEAD_BEEF, 3,
               64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 64'd0, 1'b0, 4, 5, 64'hDEAD_BEEF_0000_0000);
    run_access("misalign_h", 1'b0, MTIMECMP_ADDR + 64'd1, 2'd1, 1'b0, '0, 0, 64'h1234, 2'b00,
               64'd0, 1'b1, 0, 1, 64'd0);
    run_access("ld_half_s6", 1'b0, MTIMECMP_ADDR + 64'd6, 2'd1, 1'b0, '0, 1, 64'h8001_0000_0000_0000,
               2'b00, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 2, 3, 64'd0);
    run_access("ld_word_u4", 1'b0, MTIMECMP_ADDR + 64'd4, 2'd2, 1'b1, '0, 0, 64'hF000_0001_0000_0000,
               2'b00, 64'h0000_0000_F000_0001, 1'b0, 1, 2, 64'd0);
    run_access("st_byte7", 1'b1, MTIMECMP_ADDR + 64'd7, 2'd0, 1'b0, 64'h0000_0000_0000_00AB, 0,
               64'd0, 2'b00, 64'd0, 1'b0, 1, 2, 64'hAB00_0000_0000_0000);
    run_access("timeout", 1'b0, MTIME_ADDR, 2'd3, 1'b0, '0, 1000, 64'h5555, 2'b00,
               64'd0, 1'b1, TIMEOUT, TIMEOUT + 1, 64'd0);
    run_access("resp_err", 1'b0, MTIME_ADDR, 2'd3, 1'b0, '0, 0, 64'd0, 2'b01,
               64'd0, 1'b1, 1, 2, 64'd0);

    // Reset in the middle of a request: bus drops at once and nothing completes.
    @(negedge clk);
    rsp_delay = 1000;
    mem_valid_i = 1'b1; mem_write_i = 1'b0; mem_addr_i = MTIME_ADDR; mem_size_i = 2'd3;
    mem_unsigned_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mem_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreq_valid_pre", 64'(clint_valid_o), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("midreq_valid_async", 64'(clint_valid_o), 64'd0);
    chk("midreq_stall_async", 64'(mem_stall_o), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("midreq_no_done", 64'(mem_done_o), 64'd0);
    end
    rst = 1'b1;
    run_access("post_rst_ld", 1'b0, MTIME_ADDR, 2'd3, 1'b0, '0, 0, 64'hCAFE_F00D_1234_5678, 2'b00,
               64'hCAFE_F00D_1234_5678, 1'b0, 1, 2, 64'd0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
